branch_result_writeback: RTL and testbench
==========================================

// Module: branch_result_writeback
// PURPOSE
//  Consumer end of the 32-bit branch/ALU result bus {Result2[31:16], Result1[15:0]} produced by the
//  execute-stage result unit. It sits between that bus and the single-write-port register file and
//  turns each result into register-file writes. It also serialises SWAP (select 3'b011) into two
//  consecutive writes and back-pressures the pipeline while the second write is pending.
// PARAMETERS
//  DATA_W   16  width of each result half and of the register-file write data
//  ADDR_W    4  register-file address width
//  SWAP_SEL 3'b011  select code that requires the upper half to be written as well
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        result bus carries a valid result this cycle
//  in_ready   out  1        block can accept a result this cycle
//  in_sel     in   3        select code that produced the result
//  in_result  in   2*DATA_W {Result2, Result1}
//  in_dst_a   in   ADDR_W   destination register for Result1
//  in_dst_b   in   ADDR_W   destination register for Result2 (used only for SWAP_SEL)
//  rf_we      out  1        register-file write enable
//  rf_waddr   out  ADDR_W   register-file write address
//  rf_wdata   out  DATA_W   register-file write data
//  fwd_valid  out  1        a hi-half write is pending; fwd_addr/fwd_data are valid for bypass
//  fwd_addr   out  ADDR_W   pending hi-half destination
//  fwd_data   out  DATA_W   pending hi-half data
// BEHAVIOUR
//  - Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, fwd_valid=0, fwd_addr=0, fwd_data=0,
//    pending flag cleared, in_ready=1 after release. A pending hi write is discarded, never issued.
//  - Transfer happens in cycle N when in_valid && in_ready.
//  - All rf_* outputs are registered. Latency is 1 cycle. A transfer in N gives rf_we=1,
//    rf_waddr=in_dst_a, rf_wdata=in_result[DATA_W-1:0] in N+1.
//  - Without a transfer, rf_we=0 in the next cycle. rf_waddr/rf_wdata then hold their last value.
//  - State: IDLE (pending=0) and HI_PEND (pending=1). in_ready = !pending (combinational).
//  - IDLE -> HI_PEND on a transfer with in_sel==SWAP_SEL. This latches fwd_addr=in_dst_b and
//    fwd_data=in_result[2*DATA_W-1:DATA_W], and fwd_valid=1 in N+1.
//  - HI_PEND -> IDLE unconditionally after one cycle. In N+2: rf_we=1, rf_waddr=fwd_addr,
//    rf_wdata=fwd_data, fwd_valid=0.
//  - in_valid in HI_PEND is ignored, not consumed. The upstream holds its result until in_ready=1.
//  - Non-SWAP results stream back-to-back: one write per cycle, in_ready stays 1.
//  - SWAP costs 2 write cycles and lowers in_ready for exactly 1 cycle (N+1).
//  - SWAP with in_dst_a==in_dst_b issues both writes. The register ends holding Result2 (last write wins).
//  - in_sel values other than SWAP_SEL, including 3'b101-3'b111, are treated as single writes.
//    Result2 is ignored for them.
//  - No arithmetic is performed. Halves are passed bit-exact. X on in_* is ignored when in_valid=0.
// TESTING
//  1. Reset: hold rst_n=0 mid-stream -> all outputs 0 asynchronously, in_ready=1 after release.
//  2. ADD result 32'h0000_1234, dst_a=3 -> next cycle rf_we=1, waddr=3, wdata=16'h1234, in_ready stays 1.
//  3. SWAP result 32'hAAAA_5555, dst_a=1, dst_b=2:
//     - N+1: we=1, waddr=1, wdata=5555, in_ready=0, fwd_valid=1, fwd_addr=2, fwd_data=AAAA.
//     - N+2: we=1, waddr=2, wdata=AAAA, fwd_valid=0.
//  4. SWAP followed by held AND (in_valid=1 through stall) -> AND accepted only in N+2, written N+3.
//     No write is lost or duplicated.
//  5. Five back-to-back MOVE results to regs 4..8 -> five consecutive rf_we cycles in order.
//  6. rst_n=0 during HI_PEND after SWAP -> hi write never appears, fwd_valid=0.
//     A SWAP with dst_a==dst_b==6 writes lo then hi to reg 6.

Source files
------------

// File: rtl/branch_result_writeback.sv
// branch_result_writeback: turns result-bus transfers into register-file writes, splitting SWAP into lo then hi writes.
module branch_result_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter logic [2:0] SWAP_SEL = 3'b011
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_sel,
    input  logic [2*DATA_W-1:0] in_result,
    input  logic [ADDR_W-1:0]   in_dst_a,
    input  logic [ADDR_W-1:0]   in_dst_b,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                fwd_valid,
    output logic [ADDR_W-1:0]   fwd_addr,
    output logic [DATA_W-1:0]   fwd_data
);
    typedef enum logic {IDLE, HI_PEND} state_t;
    state_t state;
    logic   xfer;
    assign in_ready = (state == IDLE);
    assign xfer     = in_valid && in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if (state == HI_PEND) begin
            // the parked hi half drains unconditionally; fwd_addr/fwd_data keep their value
            state     <= IDLE;
            rf_we     <= 1'b1;
            rf_waddr  <= fwd_addr;
            rf_wdata  <= fwd_data;
            fwd_valid <= 1'b0;
        end else begin
            rf_we <= xfer;
            if (xfer) begin
                rf_waddr <= in_dst_a;
                rf_wdata <= in_result[DATA_W-1:0];
            end
            if (xfer && in_sel == SWAP_SEL) begin
                state     <= HI_PEND;
                fwd_valid <= 1'b1;
                fwd_addr  <= in_dst_b;
                fwd_data  <= in_result[2*DATA_W-1:DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_branch_result_writeback.sv
// tb_branch_result_writeback: queue-of-writes model checked every cycle, plus literal spot checks.
module tb_branch_result_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_sel = 3'b000;
    logic [31:0] in_result = 32'h0;
    logic [3:0]  in_dst_a = 4'h0;
    logic [3:0]  in_dst_b = 4'h0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [15:0] fwd_data;
    int vec = 0;
    int err = 0;

    branch_result_writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_result(in_result), .in_dst_a(in_dst_a), .in_dst_b(in_dst_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Model: every accepted result becomes a list of register writes retired one per cycle;
    // the bus is ready only when no write is left outstanding.
    typedef struct packed {logic [3:0] a; logic [15:0] d;} wr_t;
    wr_t         q[$];
    wr_t         w;
    logic        m_we = 1'b0;
    logic [3:0]  m_addr = 4'h0;
    logic [15:0] m_data = 16'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_we = 1'b0;
            m_addr = 4'h0;
            m_data = 16'h0;
        end else begin
            if (in_valid && q.size() == 0) begin
                q.push_back({in_dst_a, in_result[15:0]});
                if (in_sel == 3'b011) q.push_back({in_dst_b, in_result[31:16]});
            end
            if (q.size() > 0) begin
                w = q.pop_front();
                m_we = 1'b1;
                m_addr = w.a;
                m_data = w.d;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_rdy, e_fv;
        logic [3:0]  e_fa;
        logic [15:0] e_fd;
        e_rdy = (q.size() == 0);
        e_fv  = (q.size() != 0);
        e_fa  = e_fv ? q[0].a : fwd_addr;
        e_fd  = e_fv ? q[0].d : fwd_data;
        vec++;
        if (rf_we !== m_we || rf_waddr !== m_addr || rf_wdata !== m_data || in_ready !== e_rdy ||
            fwd_valid !== e_fv || fwd_addr !== e_fa || fwd_data !== e_fd) begin
            err++;
            $display("FAIL cycle t=%0t: got we=%b wa=%h wd=%h rdy=%b fv=%b fa=%h fd=%h expected we=%b wa=%h wd=%h rdy=%b fv=%b fa=%h fd=%h",
                     $time, rf_we, rf_waddr, rf_wdata, in_ready, fwd_valid, fwd_addr, fwd_data,
                     m_we, m_addr, m_data, e_rdy, e_fv, e_fa, e_fd);
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Drive one result and hold it until a clock edge sees in_ready high; returns just after that edge.
    task automatic push(input logic [2:0] s, input logic [31:0] r, input logic [3:0] a, input logic [3:0] b);
        logic acc;
        int   n;
        in_valid = 1'b1; in_sel = s; in_result = r; in_dst_a = a; in_dst_b = b;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 10) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            n++;
        end
        if (!acc) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_result = $urandom;
        in_sel = 3'($urandom);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_we"}, {31'h0, rf_we}, 32'h0);
        chk({n, "_wa"}, {28'h0, rf_waddr}, 32'h0);
        chk({n, "_wd"}, {16'h0, rf_wdata}, 32'h0);
        chk({n, "_fv"}, {31'h0, fwd_valid}, 32'h0);
        chk({n, "_fa"}, {28'h0, fwd_addr}, 32'h0);
        chk({n, "_fd"}, {16'h0, fwd_data}, 32'h0);
    endtask

    initial begin
        #3 chk_zero("reset_initial");
        #20 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("ready_after_reset", {31'h0, in_ready}, 32'h1);

        // single ADD write
        push(3'b000, 32'h0000_1234, 4'd3, 4'd9);
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_we", {31'h0, rf_we}, 32'h1);
        chk("add_wa", {28'h0, rf_waddr}, 32'h3);
        chk("add_wd", {16'h0, rf_wdata}, 32'h1234);
        chk("add_rdy", {31'h0, in_ready}, 32'h1);
        idle(2);

        // SWAP split into lo then hi
        push(3'b011, 32'hAAAA_5555, 4'd1, 4'd2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("swap1_wa", {28'h0, rf_waddr}, 32'h1);
        chk("swap1_wd", {16'h0, rf_wdata}, 32'h5555);
        chk("swap1_rdy", {31'h0, in_ready}, 32'h0);
        chk("swap1_fv", {31'h0, fwd_valid}, 32'h1);
        chk("swap1_fa", {28'h0, fwd_addr}, 32'h2);
        chk("swap1_fd", {16'h0, fwd_data}, 32'hAAAA);
        @(negedge clk);
        chk("swap2_we", {31'h0, rf_we}, 32'h1);
        chk("swap2_wa", {28'h0, rf_waddr}, 32'h2);
        chk("swap2_wd", {16'h0, rf_wdata}, 32'hAAAA);
        chk("swap2_fv", {31'h0, fwd_valid}, 32'h0);
        idle(2);

        // SWAP followed by an AND held through the stall
        push(3'b011, 32'h1111_2222, 4'd10, 4'd11);
        push(3'b010, 32'hFFFF_0F0F, 4'd12, 4'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("and_wa", {28'h0, rf_waddr}, 32'hC);
        chk("and_wd", {16'h0, rf_wdata}, 32'h0F0F);
        idle(2);

        // five back-to-back MOVEs, then the unused selects 101..111 with junk upper halves
        for (int i = 4; i <= 8; i++) push(3'b100, {16'hDEAD, 16'(i * 16'h0101)}, 4'(i), 4'hF);
        for (int i = 5; i <= 7; i++) push(3'(i), {16'hBEEF, 16'(16'h7000 + i)}, 4'(i + 8), 4'h1);
        idle(3);

        // reset mid-stream drops outputs asynchronously
        push(3'b001, 32'h0000_4321, 4'd7, 4'd0);
        push(3'b001, 32'h0000_8765, 4'd8, 4'd0);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        #1 chk_zero("reset_mid");
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("ready_mid_release", {31'h0, in_ready}, 32'h1);
        idle(2);

        // reset while the hi half is pending discards it
        push(3'b011, 32'hCAFE_BABE, 4'd13, 4'd14);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pend_fv", {31'h0, fwd_valid}, 32'h1);
        #1 rst_n = 1'b0;
        #1 chk_zero("reset_pend");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("pend_no_hi", {31'h0, rf_we}, 32'h0);
        idle(2);

        // SWAP to the same register writes lo then hi
        push(3'b011, 32'h6666_3333, 4'd6, 4'd6);
        in_valid = 1'b0;
        @(negedge clk);
        chk("same_lo", {12'h0, rf_waddr, rf_wdata}, 32'h0006_3333);
        @(negedge clk);
        chk("same_hi", {12'h0, rf_waddr, rf_wdata}, 32'h0006_6666);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
